// File: rtl/core_pixel_buf.sv
// 8x8 pixel rotation buffer: fills one 64-pixel set in raster order, then drains it
// rotated by the quarter-turn setting captured on the first write of the set.
module core_pixel_buf #(
  parameter int PIX_W = 24
) (
  input  logic             I_HCLK,
  input  logic             I_HRESET_N,
  input  logic             I_CLEAR,
  input  logic             I_DIRECTION,
  input  logic [1:0]       I_DEGREES,
  input  logic             I_WR_EN,
  input  logic [PIX_W-1:0] I_WDATA,
  input  logic             I_RD_EN,
  output logic [PIX_W-1:0] O_RDATA,
  output logic             O_VALID,
  output logic             O_FULL,
  output logic             O_EMPTY,
  output logic [6:0]       O_LEVEL,
  output logic             O_OVF,
  output logic             O_UNF,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [PIX_W-1:0] mem [64];
  logic [5:0]       wr_idx, rd_idx;
  logic [6:0]       level;
  logic             dir_q;
  logic [1:0]       deg_q;
  logic             wr_phase, wr_ok, wr_bad, rd_ok, rd_bad;
  logic [1:0]       q;
  logic [2:0]       rr, cc, src_row, src_col;
  logic [5:0]       src_idx;

  // Strobe handshake: a write (read) is accepted in the cycle I_WR_EN (I_RD_EN) is
  // high and the state allows it; the read response appears with O_VALID one cycle
  // later. There is no back-pressure: an illegal strobe is dropped and flagged.
  always_comb begin
    wr_phase = (state == ST_EMPTY) || (state == ST_FILL);
    wr_ok    = I_WR_EN && wr_phase  && !I_CLEAR;
    wr_bad   = I_WR_EN && !wr_phase && !I_CLEAR;
    rd_ok    = I_RD_EN && !wr_phase && !I_CLEAR;
    rd_bad   = I_RD_EN && wr_phase  && !I_CLEAR;
  end

  always_comb begin
    state_nxt = state;
    if (I_CLEAR) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (wr_ok) state_nxt = ST_FILL;
        ST_FILL:  if (wr_ok && wr_idx == 6'd63) state_nxt = ST_FULL;
        ST_FULL:  if (rd_ok) state_nxt = ST_DRAIN;
        ST_DRAIN: if (rd_ok && rd_idx == 6'd63) state_nxt = ST_EMPTY;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Counter-clockwise turns become the complementary clockwise count (2-bit wrap).
  always_comb begin
    q  = dir_q ? deg_q : (2'd0 - deg_q);
    rr = rd_idx[5:3];
    cc = rd_idx[2:0];
    src_row = rr;
    src_col = cc;
    case (q)
      2'd0: begin src_row = rr;        src_col = cc;        end
      2'd1: begin src_row = 3'd7 - cc; src_col = rr;        end
      2'd2: begin src_row = 3'd7 - rr; src_col = 3'd7 - cc; end
      2'd3: begin src_row = cc;        src_col = 3'd7 - rr; end
      default: begin src_row = rr;     src_col = cc;        end
    endcase
    src_idx = {src_row, src_col};
  end

  // Pixel storage is deliberately not reset; reads are blocked until a full set exists.
  always_ff @(posedge I_HCLK) begin
    if (wr_ok) mem[wr_idx] <= I_WDATA;
  end

  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      state   <= ST_EMPTY;
      wr_idx  <= '0;
      rd_idx  <= '0;
      level   <= '0;
      dir_q   <= 1'b0;
      deg_q   <= 2'd0;
      O_RDATA <= '0;
      O_VALID <= 1'b0;
      O_OVF   <= 1'b0;
      O_UNF   <= 1'b0;
    end else begin
      state   <= state_nxt;
      O_OVF   <= wr_bad;
      O_UNF   <= rd_bad;
      O_VALID <= rd_ok;
      if (I_CLEAR) begin
        wr_idx <= '0;
        rd_idx <= '0;
        level  <= '0;
      end else begin
        if (wr_ok) begin
          wr_idx <= wr_idx + 6'd1;
          level  <= level + 7'd1;
          if (state == ST_EMPTY) begin
            dir_q <= I_DIRECTION;
            deg_q <= I_DEGREES;
          end
        end
        if (rd_ok) begin
          rd_idx  <= rd_idx + 6'd1;
          level   <= level - 7'd1;
          O_RDATA <= mem[src_idx];
        end
      end
    end
  end

  assign O_FULL    = (state == ST_FULL);
  assign O_EMPTY   = (state == ST_EMPTY);
  assign O_LEVEL   = level;
  assign dbg_state = state;

endmodule

// File: tb/tb_core_pixel_buf.sv
// Directed bench for core_pixel_buf: fill/drain at each rotation, error pulses,
// clear, mid-drain reset and mid-fill degree change.
module tb_core_pixel_buf;
  localparam int PIX_W = 24;

  logic             clk = 1'b0;
  logic             rst_n, clr, dir_in, wr_en, rd_en;
  logic [1:0]       deg_in;
  logic [PIX_W-1:0] wdata, rdata;
  logic             valid, full, empty, ovf, unf;
  logic [6:0]       level;
  logic [1:0]       dbg_state;

  logic [PIX_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  core_pixel_buf #(.PIX_W(PIX_W)) dut (
    .I_HCLK(clk), .I_HRESET_N(rst_n), .I_CLEAR(clr), .I_DIRECTION(dir_in),
    .I_DEGREES(deg_in), .I_WR_EN(wr_en), .I_WDATA(wdata), .I_RD_EN(rd_en),
    .O_RDATA(rdata), .O_VALID(valid), .O_FULL(full), .O_EMPTY(empty),
    .O_LEVEL(level), .O_OVF(ovf), .O_UNF(unf), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raster index of the source pixel for output index k after q clockwise turns.
  function automatic int src_of(input logic [1:0] q, input int k);
    int r, c;
    r = k / 8;
    c = k % 8;
    case (q)
      2'd0: return k;
      2'd1: return 8 * (7 - c) + r;
      2'd2: return 8 * (7 - r) + (7 - c);
      default: return 8 * c + (7 - r);
    endcase
  endfunction

  task automatic fill(input logic dir, input logic [1:0] deg, input int change_at,
                      input logic [1:0] new_deg);
    dir_in = dir;
    deg_in = deg;
    for (int i = 0; i < 64; i++) begin
      if (i == change_at) deg_in = new_deg;
      wr_en = 1'b1;
      wdata = PIX_W'(i);
      step();
    end
    wr_en = 1'b0;
    check("full_after_fill", full, 1);
    check("level_after_fill", level, 64);
  endtask

  task automatic read_one(input logic [PIX_W-1:0] exp);
    exp_q.push_back(exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("rd_valid", valid, 1);
    check("rd_data", rdata, exp_q.pop_front());
  endtask

  task automatic drain(input logic [1:0] q, input int start, input int n);
    for (int k = start; k < start + n; k++) read_one(PIX_W'(src_of(q, k)));
  endtask

  task automatic check_drained();
    check("empty_after_drain", empty, 1);
    check("level_after_drain", level, 0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; dir_in = 1'b0; deg_in = 2'd0;
    wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    repeat (2) step();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_valid", valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    rst_n = 1'b1;
    step();

    // Read while empty: one-cycle underflow pulse, no data.
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("unf_pulse", unf, 1);
    check("unf_no_valid", valid, 0);
    step();
    check("unf_drop", unf, 0);

    // Identity rotation; also overflow write in FULL must not corrupt index 0.
    fill(1'b1, 2'd0, -1, 2'd0);
    wr_en = 1'b1; wdata = 24'hABCDEF; step(); wr_en = 1'b0;
    check("ovf_pulse", ovf, 1);
    check("ovf_level", level, 64);
    check("ovf_full", full, 1);
    step();
    check("ovf_drop", ovf, 0);
    read_one(24'h000000);
    read_one(24'h000001);
    drain(2'd0, 2, 62);
    check_drained();
    step();
    check("valid_idle", valid, 0);
    check("rdata_hold", rdata, 24'h00003F);

    // 90 deg clockwise.
    fill(1'b1, 2'd1, -1, 2'd0);
    read_one(24'h38); read_one(24'h30); read_one(24'h28);
    read_one(24'h20); read_one(24'h18); read_one(24'h10);
    read_one(24'h08); read_one(24'h00); read_one(24'h39);
    drain(2'd1, 9, 55);
    check_drained();

    // 90 deg counter-clockwise == 270 clockwise.
    fill(1'b0, 2'd1, -1, 2'd0);
    read_one(24'h07); read_one(24'h0F); read_one(24'h17);
    drain(2'd3, 3, 61);
    check_drained();
    fill(1'b1, 2'd3, -1, 2'd0);
    read_one(24'h07); read_one(24'h0F); read_one(24'h17);
    drain(2'd3, 3, 61);
    check_drained();

    // 180 deg.
    fill(1'b1, 2'd2, -1, 2'd0);
    read_one(24'h3F); read_one(24'h3E); read_one(24'h3D);
    drain(2'd2, 3, 61);
    check_drained();

    // Reset in the middle of a drain discards the set immediately.
    fill(1'b1, 2'd0, -1, 2'd0);
    drain(2'd0, 0, 20);
    check("level_mid_drain", level, 44);
    rst_n = 1'b0;
    #1;
    check("async_rst_level", level, 0);
    check("async_rst_empty", empty, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    fill(1'b1, 2'd0, -1, 2'd0);
    drain(2'd0, 0, 64);
    check_drained();

    // Degree change during fill is ignored.
    fill(1'b1, 2'd1, 10, 2'd2);
    drain(2'd1, 0, 64);
    check_drained();

    // Clear beats a simultaneous write, without an error pulse.
    dir_in = 1'b1; deg_in = 2'd0;
    for (int i = 0; i < 30; i++) begin
      wr_en = 1'b1; wdata = PIX_W'(i); step();
    end
    check("level_partial", level, 30);
    clr = 1'b1; wr_en = 1'b1; step(); clr = 1'b0; wr_en = 1'b0;
    check("clr_empty", empty, 1);
    check("clr_level", level, 0);
    check("clr_ovf", ovf, 0);

    // Write and read together while empty: write wins, read flags underflow.
    wr_en = 1'b1; rd_en = 1'b1; wdata = 24'h000005; step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("simul_level", level, 1);
    check("simul_unf", unf, 1);
    check("simul_valid", valid, 0);
    check("simul_empty", empty, 0);
    clr = 1'b1; step(); clr = 1'b0;
    check("clr2_level", level, 0);

    // A clean set after clear starts at index 0.
    fill(1'b1, 2'd0, -1, 2'd0);
    drain(2'd0, 0, 64);
    check_drained();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
